id_ex_controller: RTL

Registered decode and hazard controller for the 5-stage MIPS pipeline, and the pipelined successor to the single-cycle combinational decoder. Decodes the ID-stage instruction into a control bundle and registers it into the ID/EX boundary. Adds load-use interlock with a configurable load latency, branch/jump flush, illegal-opcode flagging, and a syscall drain/halt state machine with a resume handshake.

---
 rtl/id_ex_controller_pkg.sv | 83 ++++++++
 rtl/id_ex_controller_instr_decode.sv | 76 +++++++
 rtl/id_ex_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_controller_pkg.sv
// Shared MIPS decode encodings: opcodes, functs, ALU selects, mux selects,
// the decoded control bundle and the syscall FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL     = 6'h00;
  localparam logic [5:0] F_SRL     = 6'h02;
  localparam logic [5:0] F_SRA     = 6'h03;
  localparam logic [5:0] F_SRAV    = 6'h07;
  localparam logic [5:0] F_JR      = 6'h08;
  localparam logic [5:0] F_SYSCALL = 6'h0c;
  localparam logic [5:0] F_ADD     = 6'h20;
  localparam logic [5:0] F_ADDU    = 6'h21;
  localparam logic [5:0] F_SUB     = 6'h22;
  localparam logic [5:0] F_AND     = 6'h24;
  localparam logic [5:0] F_OR      = 6'h25;
  localparam logic [5:0] F_NOR     = 6'h27;
  localparam logic [5:0] F_SLT     = 6'h2a;
  localparam logic [5:0] F_SLTU    = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_NOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SRAV = 4'd9
  } alu_op_e;

  localparam logic [1:0] RW_RD  = 2'b00;
  localparam logic [1:0] RW_R31 = 2'b01;
  localparam logic [1:0] RW_RT  = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC4 = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b11;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_BLEZ = 2'b11;

  typedef struct packed {
    logic       we;
    logic [1:0] rw_sel;
    logic [1:0] wb_sel;
    alu_op_e    alu_op;
    logic       shamt_sel;
    logic       mem_load;
    logic       mem_store;
    logic       half;
    logic [1:0] br_kind;
    logic       jump;
    logic       jr;
    logic       syscall;
    logic       illegal;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } sys_state_e;

endpackage

// File: rtl/id_ex_controller_instr_decode.sv
// Combinational MIPS decoder: opcode/funct in, control bundle out.
// Illegal encodings leave we/load/store at 0 and raise illegal.
module instr_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_uses_rt
);

  always_comb begin
    o_ctrl    = '0;
    o_uses_rt = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_uses_rt  = 1'b1;
        o_ctrl.we  = 1'b1;
        case (i_funct)
          F_ADD, F_ADDU: o_ctrl.alu_op = ALU_ADD;
          F_SUB:         o_ctrl.alu_op = ALU_SUB;
          F_AND:         o_ctrl.alu_op = ALU_AND;
          F_OR:          o_ctrl.alu_op = ALU_OR;
          F_NOR:         o_ctrl.alu_op = ALU_NOR;
          F_SLT, F_SLTU: o_ctrl.alu_op = ALU_SLT;
          F_SLL: begin o_ctrl.alu_op = ALU_SLL; o_ctrl.shamt_sel = 1'b1; end
          F_SRL: begin o_ctrl.alu_op = ALU_SRL; o_ctrl.shamt_sel = 1'b1; end
          F_SRA: begin o_ctrl.alu_op = ALU_SRA; o_ctrl.shamt_sel = 1'b1; end
          F_SRAV:        o_ctrl.alu_op = ALU_SRAV;
          F_JR:      begin o_ctrl.we = 1'b0; o_ctrl.jr = 1'b1; end
          F_SYSCALL: begin o_ctrl.we = 1'b0; o_ctrl.syscall = 1'b1; end
          default:   begin o_ctrl.we = 1'b0; o_ctrl.illegal = 1'b1; end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: begin
        o_ctrl.we     = 1'b1;
        o_ctrl.rw_sel = RW_RT;
        case (i_op)
          OP_ANDI: o_ctrl.alu_op = ALU_AND;
          OP_ORI:  o_ctrl.alu_op = ALU_OR;
          OP_SLTI: o_ctrl.alu_op = ALU_SLT;
          default: o_ctrl.alu_op = ALU_ADD;
        endcase
      end
      OP_LW, OP_LH: begin
        o_ctrl.we       = 1'b1;
        o_ctrl.rw_sel   = RW_RT;
        o_ctrl.wb_sel   = WB_MEM;
        o_ctrl.mem_load = 1'b1;
        o_ctrl.half     = (i_op == OP_LH);
      end
      OP_SW: begin
        o_uses_rt        = 1'b1;
        o_ctrl.mem_store = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ: begin
        o_uses_rt     = 1'b1;
        o_ctrl.alu_op = ALU_SUB;
        case (i_op)
          OP_BEQ:  o_ctrl.br_kind = BR_BEQ;
          OP_BNE:  o_ctrl.br_kind = BR_BNE;
          default: o_ctrl.br_kind = BR_BLEZ;
        endcase
      end
      OP_J: o_ctrl.jump = 1'b1;
      OP_JAL: begin
        o_ctrl.jump   = 1'b1;
        o_ctrl.we     = 1'b1;
        o_ctrl.rw_sel = RW_R31;
        o_ctrl.wb_sel = WB_PC4;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_controller.sv
// ID/EX boundary register with load-use interlock, branch flush and a
// syscall drain/halt state machine with a resume handshake.
module id_ex_controller
  import mips_pkg::*;
#(
  parameter int unsigned ALU_OP_W     = 4,
  parameter int unsigned LOAD_DELAY   = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_instr,
  input  logic                ex_flush,
  input  logic                resume,
  output logic                stall,
  output logic                halted,
  output logic                ex_valid,
  output logic                ex_we,
  output logic [1:0]          ex_rw_sel,
  output logic [1:0]          ex_wb_sel,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_shamt_sel,
  output logic                ex_mem_load,
  output logic                ex_mem_store,
  output logic                ex_half,
  output logic [1:0]          ex_br_kind,
  output logic                ex_jump,
  output logic                ex_jr,
  output logic                ex_syscall,
  output logic                ex_illegal,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_rd
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  ctrl_t            w_dec;
  logic             w_uses_rt;
  logic [4:0]       w_id_rs, w_id_rt, w_id_rd;
  logic             w_unused_shamt;

  logic             r_ex_valid;
  ctrl_t            r_ex_ctrl;
  logic [4:0]       r_ex_rs, r_ex_rt, r_ex_rd;
  logic             r_sh_valid;
  logic [4:0]       r_sh_rt;

  sys_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_ex_hit, w_sh_hit, w_hazard, w_bubble;

  assign w_id_rs        = id_instr[25:21];
  assign w_id_rt        = id_instr[20:16];
  assign w_id_rd        = id_instr[15:11];
  assign w_unused_shamt = ^id_instr[10:6];

  instr_decode u_decode (
    .i_op      (id_instr[31:26]),
    .i_funct   (id_instr[5:0]),
    .o_ctrl    (w_dec),
    .o_uses_rt (w_uses_rt)
  );

  // Hazard sources are registered state only, so stall never depends on ex_* outputs.
  assign w_ex_hit = r_ex_valid && r_ex_ctrl.mem_load && (r_ex_rt != '0) &&
                    ((r_ex_rt == w_id_rs) || (w_uses_rt && (r_ex_rt == w_id_rt)));
  assign w_sh_hit = r_sh_valid &&
                    ((r_sh_rt == w_id_rs) || (w_uses_rt && (r_sh_rt == w_id_rt)));
  assign w_hazard = id_valid && (w_ex_hit || w_sh_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (r_ex_valid && r_ex_ctrl.syscall) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = CNT_W'(DRAIN_CYCLES);
        end
      end
      ST_DRAIN: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_HALT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_HALT: begin
        if (resume) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    stall    = !ex_flush && ((r_state != ST_RUN) || w_hazard);
    halted   = (r_state == ST_HALT);
    w_bubble = ex_flush || (r_state != ST_RUN) || w_hazard || !id_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_rd    <= '0;
    end else if (w_bubble) begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_rd    <= '0;
    end else begin
      r_ex_valid <= 1'b1;
      r_ex_ctrl  <= w_dec;
      r_ex_rs    <= w_id_rs;
      r_ex_rt    <= w_id_rt;
      r_ex_rd    <= w_id_rd;
    end
  end

  // Shadow holds the load that just left EX, extending its hazard window by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_valid <= 1'b0;
      r_sh_rt    <= '0;
    end else if (LOAD_DELAY >= 2) begin
      r_sh_valid <= r_ex_valid && r_ex_ctrl.mem_load && (r_ex_rt != '0);
      r_sh_rt    <= r_ex_rt;
    end else begin
      r_sh_valid <= 1'b0;
      r_sh_rt    <= '0;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_we        = r_ex_ctrl.we;
  assign ex_rw_sel    = r_ex_ctrl.rw_sel;
  assign ex_wb_sel    = r_ex_ctrl.wb_sel;
  assign ex_alu_op    = ALU_OP_W'(r_ex_ctrl.alu_op);
  assign ex_shamt_sel = r_ex_ctrl.shamt_sel;
  assign ex_mem_load  = r_ex_ctrl.mem_load;
  assign ex_mem_store = r_ex_ctrl.mem_store;
  assign ex_half      = r_ex_ctrl.half;
  assign ex_br_kind   = r_ex_ctrl.br_kind;
  assign ex_jump      = r_ex_ctrl.jump;
  assign ex_jr        = r_ex_ctrl.jr;
  assign ex_syscall   = r_ex_ctrl.syscall;
  assign ex_illegal   = r_ex_ctrl.illegal;
  assign ex_rs        = r_ex_rs;
  assign ex_rt        = r_ex_rt;
  assign ex_rd        = r_ex_rd;

endmodule
